imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface: the CPU only reads instruction memory, and this block fills it.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader_timeout.sv | 29 ++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_loader_pkg;

  // Default frame start marker.
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // States in which the byte stream is accepted.
  function automatic logic takes_rx(input state_t s);
    return (s == ST_HUNT) || (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

  // States inside a frame, where the inter-byte timer runs.
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

  // LEN byte to data-byte count; zero encodes a full 256-byte image.
  function automatic logic [8:0] frame_count(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//
// Handshake: the byte source holds rx_valid and rx_data stable until a rising
// edge where rx_valid & rx_ready are both 1; that edge transfers exactly one
// byte. rx_ready may drop at any time and never depends on rx_valid.
// The write port is a plain strobe: im_we is high for one cycle per byte,
// with im_waddr/im_wdata valid in that same cycle.
interface imem_loader_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       im_we;
  logic [7:0] im_waddr;
  logic [7:0] im_wdata;

  // Loader side: consumes bytes, drives memory writes.
  modport master (
    input  rx_valid, rx_data,
    output rx_ready, im_we, im_waddr, im_wdata
  );

  // Environment side: byte source and instruction memory.
  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, im_we, im_waddr, im_wdata
  );
endinterface

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle timer: clear/enable counter that flags when TIMEOUT-1
// idle cycles have elapsed inside a frame.
module loader_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  // Count idle cycles while enabled; saturate at the expiry value.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses SYNC, LEN, data, CHK frames from a byte
// stream, writes the data bytes to instruction memory and releases the CPU
// only after a frame with a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         TIMEOUT   = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  imem_loader_if.master        bus,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_err,
  output state_t               state_o
);

  state_t     state_q;
  logic [8:0] count_q;
  logic [8:0] idx_q;
  logic [7:0] sum_q;
  logic       cpu_hold_q;
  logic       load_done_q;
  logic       load_err_q;
  logic       im_we_q;
  logic [7:0] im_waddr_q;
  logic [7:0] im_wdata_q;

  logic [8:0] idx_d;
  logic [7:0] sum_d;
  logic       rx_acc;
  logic       timer_clear;
  logic       timer_en;
  logic       timer_expired;

  // Ready depends only on the state register and start, never on rx_valid.
  assign bus.rx_ready = takes_rx(state_q) & ~start;
  assign rx_acc       = bus.rx_valid & bus.rx_ready;

  assign idx_d = idx_q + 9'd1;
  assign sum_d = sum_q + bus.rx_data;

  // Timer restarts on every accepted byte and stays cleared outside a frame.
  assign timer_en    = in_frame(state_q);
  assign timer_clear = rx_acc | start | ~timer_en;

  loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (timer_clear),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // Frame FSM with registered status flags and memory write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      count_q     <= '0;
      idx_q       <= '0;
      sum_q       <= '0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      im_we_q     <= 1'b0;
      im_waddr_q  <= BASE_ADDR;
      im_wdata_q  <= '0;
    end else if (start) begin
      // start wins over any same-cycle byte; memory contents are left as is.
      state_q     <= ST_HUNT;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      im_we_q     <= 1'b0;
    end else begin
      im_we_q <= 1'b0;
      unique case (state_q)
        ST_HUNT: begin
          if (rx_acc && (bus.rx_data == SYNC_BYTE)) state_q <= ST_LEN;
        end
        ST_LEN: begin
          if (rx_acc) begin
            count_q <= frame_count(bus.rx_data);
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= ST_DATA;
          end else if (timer_expired) begin
            state_q    <= ST_ERR;
            load_err_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_acc) begin
            im_we_q    <= 1'b1;
            im_waddr_q <= BASE_ADDR + idx_q[7:0];
            im_wdata_q <= bus.rx_data;
            sum_q      <= sum_d;
            idx_q      <= idx_d;
            if (idx_d == count_q) state_q <= ST_CHK;
          end else if (timer_expired) begin
            state_q    <= ST_ERR;
            load_err_q <= 1'b1;
          end
        end
        ST_CHK: begin
          if (rx_acc) begin
            if (sum_d == 8'h00) begin
              state_q     <= ST_DONE;
              cpu_hold_q  <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              state_q    <= ST_ERR;
              load_err_q <= 1'b1;
            end
          end else if (timer_expired) begin
            state_q    <= ST_ERR;
            load_err_q <= 1'b1;
          end
        end
        ST_DONE, ST_ERR: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= ST_HUNT;
        end
      endcase
    end
  end

  assign bus.im_we    = im_we_q;
  assign bus.im_waddr = im_waddr_q;
  assign bus.im_wdata = im_wdata_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 00 and base FE, short timeout),
// directed frames, write scoreboard with expected queues and flag checks.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic   clk;
  logic   rst;
  logic   start_a, start_b;
  logic   hold_a, done_a, err_a;
  logic   hold_b, done_b, err_b;
  state_t st_a, st_b;

  imem_loader_if ifa ();
  imem_loader_if ifb ();

  imem_loader #(.SYNC_BYTE(8'hA5), .BASE_ADDR(8'h00), .TIMEOUT(16)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa.master),
    .cpu_hold(hold_a), .load_done(done_a), .load_err(err_a), .state_o(st_a)
  );

  imem_loader #(.SYNC_BYTE(8'hA5), .BASE_ADDR(8'hFE), .TIMEOUT(16)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb.master),
    .cpu_hold(hold_b), .load_done(done_b), .load_err(err_b), .state_o(st_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int writes_a = 0;
  int writes_b = 0;
  logic [15:0] exp_qa[$];
  logic [15:0] exp_qb[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitors: every write strobe pops one expected (addr,data)
  always @(negedge clk) begin
    if (!rst && ifa.im_we === 1'b1) begin
      writes_a++;
      n_checks++;
      if (exp_qa.size() == 0) begin
        n_fail++;
        $display("FAIL wr_a: got unexpected write %h@%h, required none", ifa.im_wdata, ifa.im_waddr);
      end else begin
        logic [15:0] e;
        e = exp_qa.pop_front();
        if ({ifa.im_waddr, ifa.im_wdata} !== e) begin
          n_fail++;
          $display("FAIL wr_a: got %h@%h, required %h@%h", ifa.im_wdata, ifa.im_waddr, e[7:0], e[15:8]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.im_we === 1'b1) begin
      writes_b++;
      n_checks++;
      if (exp_qb.size() == 0) begin
        n_fail++;
        $display("FAIL wr_b: got unexpected write %h@%h, required none", ifb.im_wdata, ifb.im_waddr);
      end else begin
        logic [15:0] e;
        e = exp_qb.pop_front();
        if ({ifb.im_waddr, ifb.im_wdata} !== e) begin
          n_fail++;
          $display("FAIL wr_b: got %h@%h, required %h@%h", ifb.im_wdata, ifb.im_waddr, e[7:0], e[15:8]);
        end
      end
    end
  end

  // driver tasks (all return at posedge+1)
  task automatic set_rx(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin ifa.rx_valid = v; ifa.rx_data = d; end
    else begin ifb.rx_valid = v; ifb.rx_data = d; end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? ifa.rx_ready : ifb.rx_ready;
  endfunction

  task automatic push_exp(input int sel, input logic [7:0] a, input logic [7:0] d);
    if (sel == 0) exp_qa.push_back({a, d});
    else exp_qb.push_back({a, d});
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b);
    logic rdy;
    int   t;
    set_rx(sel, 1'b1, b);
    rdy = 1'b0;
    t = 0;
    while (!rdy && t < 50) begin
      @(negedge clk);
      rdy = get_ready(sel);
      @(posedge clk);
      #1;
      t++;
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_%0d: byte %h got no rx_ready within 50 cycles", sel, b);
    end
  endtask

  task automatic idle(input int sel, input int n);
    set_rx(sel, 1'b0, 8'h00);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int sel, input logic v, input logic [7:0] b);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    set_rx(sel, v, b);
    @(negedge clk);
    check("start_blocks_ready", {31'd0, get_ready(sel)}, 32'd0);
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    set_rx(sel, 1'b0, 8'h00);
  endtask

  // bounded wait for a frame result, then flag checks
  task automatic wait_end(input int sel, input string name, input logic ed, input logic ee, input logic eh);
    int t;
    t = 0;
    while (t < 40 && ((sel == 0) ? !(done_a | err_a) : !(done_b | err_b))) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({name, "_done"}, {31'd0, (sel == 0) ? done_a : done_b}, {31'd0, ed});
    check({name, "_err"},  {31'd0, (sel == 0) ? err_a  : err_b},  {31'd0, ee});
    check({name, "_hold"}, {31'd0, (sel == 0) ? hold_a : hold_b}, {31'd0, eh});
  endtask

  task automatic send_seq(input int sel, input logic [7:0] s[]);
    foreach (s[i]) send_byte(sel, s[i]);
    idle(sel, 1);
  endtask

  initial begin
    int   n;
    int   w0;
    logic [7:0] s[];
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    set_rx(0, 1'b0, 8'h00);
    set_rx(1, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_state",  {29'd0, st_a}, {29'd0, ST_HUNT});
    check("rst_hold",   {31'd0, hold_a}, 32'd1);
    check("rst_done",   {31'd0, done_a}, 32'd0);
    check("rst_err",    {31'd0, err_a}, 32'd0);
    check("rst_we",     {31'd0, ifa.im_we}, 32'd0);
    check("rst_waddr",  {24'd0, ifa.im_waddr}, 32'h00);
    check("rst_wdata",  {24'd0, ifa.im_wdata}, 32'h00);
    check("rst_ready",  {31'd0, ifa.rx_ready}, 32'd1);
    check("rst_waddr_b", {24'd0, ifb.im_waddr}, 32'hFE);
    @(posedge clk);
    #1;

    // good frame, three writes
    push_exp(0, 8'h00, 8'h11); push_exp(0, 8'h01, 8'h22); push_exp(0, 8'h02, 8'h33);
    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    foreach (s[i]) send_byte(0, s[i]);
    check("t1_hold_midframe", {31'd0, hold_a}, 32'd1);
    check("t1_state_chk", {29'd0, st_a}, {29'd0, ST_CHK});
    send_byte(0, 8'h9A);
    idle(0, 1);
    wait_end(0, "t1", 1'b1, 1'b0, 1'b0);
    check("t1_state", {29'd0, st_a}, {29'd0, ST_DONE});

    // start with a same-cycle byte: byte refused, back to HUNT
    pulse_start(0, 1'b1, 8'hA5);
    check("t6_state", {29'd0, st_a}, {29'd0, ST_HUNT});
    check("t6_hold",  {31'd0, hold_a}, 32'd1);
    check("t6_flags", {30'd0, done_a, err_a}, 32'd0);
    // again from HUNT: a sync byte under start must not advance to LEN
    pulse_start(0, 1'b1, 8'hA5);
    check("t6_hunt_stays", {29'd0, st_a}, {29'd0, ST_HUNT});

    // LEN=00 -> 256 bytes 00..FF, addresses 00..FF, checksum 0x80
    w0 = writes_a;
    for (int i = 0; i < 256; i++) push_exp(0, 8'(i), 8'(i));
    send_byte(0, 8'hA5);
    send_byte(0, 8'h00);
    for (int i = 0; i < 256; i++) send_byte(0, 8'(i));
    check("t6_hold_before_chk", {31'd0, hold_a}, 32'd1);
    send_byte(0, 8'h80);
    idle(0, 1);
    wait_end(0, "t6_256", 1'b1, 1'b0, 1'b0);
    check("t6_write_count", 32'(writes_a - w0), 32'd256);

    // bad checksum
    pulse_start(0, 1'b0, 8'h00);
    push_exp(0, 8'h00, 8'h11); push_exp(0, 8'h01, 8'h22); push_exp(0, 8'h02, 8'h33);
    w0 = writes_a;
    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
    send_seq(0, s);
    wait_end(0, "t2", 1'b0, 1'b1, 1'b1);
    check("t2_write_count", 32'(writes_a - w0), 32'd3);

    // junk before sync is dropped
    pulse_start(0, 1'b0, 8'h00);
    push_exp(0, 8'h00, 8'h7E);
    s = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h82};
    send_seq(0, s);
    wait_end(0, "t3", 1'b1, 1'b0, 1'b0);

    // timeout: 16 idle cycles after the first of two data bytes
    pulse_start(0, 1'b0, 8'h00);
    push_exp(0, 8'h00, 8'h10);
    s = '{8'hA5, 8'h02, 8'h10};
    foreach (s[i]) send_byte(0, s[i]);
    set_rx(0, 1'b0, 8'h00);
    n = 0;
    begin
      bit seen;
      seen = 1'b0;
      while (!seen && n < 40) begin
        @(negedge clk);
        if (err_a) seen = 1'b1;
        else begin
          n++;
          @(posedge clk);
        end
      end
    end
    check("t5_idle_cycles", 32'(n), 32'd16);
    check("t5_err",  {31'd0, err_a}, 32'd1);
    check("t5_hold", {31'd0, hold_a}, 32'd1);
    check("t5_done", {31'd0, done_a}, 32'd0);
    @(posedge clk);
    #1;
    set_rx(0, 1'b1, 8'h55);
    @(negedge clk);
    check("t5_ready_after_err", {31'd0, ifa.rx_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    idle(0, 1);
    check("t5_state", {29'd0, st_a}, {29'd0, ST_ERR});

    // base FE: addresses wrap FE, FF, 00
    push_exp(1, 8'hFE, 8'h01); push_exp(1, 8'hFF, 8'h02); push_exp(1, 8'h00, 8'h03);
    s = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    send_seq(1, s);
    wait_end(1, "t4", 1'b1, 1'b0, 1'b0);
    check("t4_write_count", 32'(writes_b), 32'd3);

    idle(0, 3);
    check("qa_empty", 32'(exp_qa.size()), 32'd0);
    check("qb_empty", 32'(exp_qb.size()), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
